// File: rtl/sp_ram_1kx32_if.sv
// Bus bundle for the single-port RAM: shared address, write enable, write data and registered read data.
interface sp_ram_1kx32_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [DATA_WIDTH-1:0] q;

  modport master (
    output data,
    output addr,
    output we,
    input  q
  );

  modport slave (
    input  data,
    input  addr,
    input  we,
    output q
  );
endinterface

// File: rtl/sp_ram_1kx32.sv
// Single-port synchronous RAM with write-first registered read (1-cycle latency).
// Reset clears only the output register; the array keeps its contents.
module sp_ram_1kx32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  sp_ram_1kx32_if.slave   bus
);

  // Declaration initialisers give deterministic all-zero power-up contents.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] q_p1 = '0;

  // Stage 0 -> array: writes ignore rst so a write coinciding with reset still lands.
  always_ff @(posedge clk) begin
    if (bus.we) begin
      mem[bus.addr] <= bus.data;
    end
  end

  // Stage 0 -> 1: output register, write-first on a same-address write.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_p1 <= '0;
    end else if (bus.we) begin
      q_p1 <= bus.data;
    end else begin
      q_p1 <= mem[bus.addr];
    end
  end

  assign bus.q = q_p1;

endmodule

// File: tb/tb_sp_ram_1kx32.sv
// Scoreboard bench for sp_ram_1kx32: stimulus queues expected q per cycle, a monitor checks after each edge.
module tb_sp_ram_1kx32;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;

  sp_ram_1kx32_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sp_ram_1kx32 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  bit          chk_q  [$];
  logic [31:0] exp_q  [$];
  string       name_q [$];

  int compared   = 0;
  int mismatched = 0;

  localparam logic [31:0] FILL [16] = '{
    32'h3C1A_9F02, 32'h7E44_0B13, 32'hB285_66D1, 32'h0F0F_F0F0,
    32'h9C2E_4A77, 32'h51D3_08EE, 32'hE7B9_1234, 32'h2468_ACE0,
    32'hFEDC_BA98, 32'h1357_9BDF, 32'h8000_0001, 32'h7FFF_FFFE,
    32'h4D5E_6F70, 32'hC3A1_5B29, 32'h0000_0000, 32'hFFFF_FFFF
  };

  // One transaction per falling edge; the entry describes q after the following rising edge.
  task automatic drive(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit chk, input logic [DW-1:0] e,
                       input string nm);
    @(negedge clk);
    rst      = r;
    bus.we   = w;
    bus.addr = a;
    bus.data = d;
    chk_q.push_back(chk);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  bit          mon_chk;
  logic [31:0] mon_exp;
  string       mon_name;

  always @(posedge clk) begin
    #1;
    if (chk_q.size() > 0) begin
      mon_chk  = chk_q.pop_front();
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      if (mon_chk) begin
        compared++;
        if (bus.q !== mon_exp) begin
          mismatched++;
          $display("FAIL %s: q=%h expected %h", mon_name, bus.q, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.data = '0;

    // Reset held for several edges keeps q at 0
    drive(1, 0, 10'd0, 32'h0, 1, 32'h0, "reset_q0");
    drive(1, 0, 10'd0, 32'h0, 1, 32'h0, "reset_hold");

    // Test 1: reset clears q but not memory
    drive(0, 1, 10'd5, 32'hDEADBEEF, 1, 32'hDEADBEEF, "t1_wr5");
    drive(1, 0, 10'd5, 32'h0,        1, 32'h0,        "t1_rst");
    drive(0, 0, 10'd5, 32'h0,        1, 32'hDEADBEEF, "t1_rd5");

    // A write presented during reset still lands in the array
    drive(1, 1, 10'd6, 32'h1357_2468, 1, 32'h0,         "rst_wr");
    drive(0, 0, 10'd6, 32'h0,         1, 32'h1357_2468, "rst_wr_rd");

    // Test 2: write-first
    drive(0, 1, 10'd0, 32'h0000_00FF, 1, 32'h0000_00FF, "t2_wf");
    drive(0, 0, 10'd0, 32'h0,         1, 32'h0000_00FF, "t2_rd");

    // Test 3: fill and back-to-back readback
    for (int i = 0; i < 16; i++)
      drive(0, 1, AW'(i), FILL[i], 1, FILL[i], "t3_wr");
    for (int i = 0; i < 16; i++)
      drive(0, 0, AW'(i), 32'h0, 1, FILL[i], "t3_rd");

    // Test 4: overwrite
    drive(0, 1, 10'd3, 32'h1234_5678, 1, 32'h1234_5678, "t4_wr1");
    drive(0, 1, 10'd3, 32'h9ABC_DEF0, 1, 32'h9ABC_DEF0, "t4_wr2");
    drive(0, 0, 10'd3, 32'h0,         1, 32'h9ABC_DEF0, "t4_rd");

    // Test 5: address boundaries, no aliasing
    drive(0, 1, 10'd0,    32'hA5A5_A5A5, 1, 32'hA5A5_A5A5, "t5_wr0");
    drive(0, 1, 10'd1023, 32'h5A5A_5A5A, 1, 32'h5A5A_5A5A, "t5_wr1023");
    drive(0, 0, 10'd1023, 32'h0,         1, 32'h5A5A_5A5A, "t5_rd1023");
    drive(0, 0, 10'd0,    32'h0,         1, 32'hA5A5_A5A5, "t5_rd0");
    drive(0, 0, 10'd1,    32'h0,         1, FILL[1],       "t5_rd1");

    // Test 6: hold with changing data and we=0
    drive(0, 1, 10'd7, 32'hC0FF_EE07, 1, 32'hC0FF_EE07, "t6_wr7");
    for (int i = 0; i < 10; i++)
      drive(0, 0, 10'd7, 32'hFFFF_0000 + 32'(i), 1, 32'hC0FF_EE07, "t6_hold");
    drive(0, 0, 10'd8, 32'h0, 1, FILL[8],       "t6_rd8");
    drive(0, 0, 10'd7, 32'h0, 1, 32'hC0FF_EE07, "t6_rd7");

    drive(0, 0, 10'd0, 32'h0, 0, 32'h0, "idle");

    for (int k = 0; k < 20 && chk_q.size() > 0; k++) @(posedge clk);
    #2;
    compared++;
    if (chk_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: pending=%0d expected 0", chk_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
